// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU sequencer: ALU opcodes,
// datapath widths and the sequencer FSM encoding.
package alu_pkg;

    localparam int ALU_W    = 16;
    localparam int ALU_OP_W = 6;

    localparam logic [ALU_OP_W-1:0] OP_ADD       = 6'b000000;
    localparam logic [ALU_OP_W-1:0] OP_INC_A     = 6'b000001;
    localparam logic [ALU_OP_W-1:0] OP_SUB       = 6'b000101;
    localparam logic [ALU_OP_W-1:0] OP_PASS_A    = 6'b001000;
    localparam logic [ALU_OP_W-1:0] OP_PASS_B    = 6'b001001;
    localparam logic [ALU_OP_W-1:0] OP_NOT_A     = 6'b001010;
    localparam logic [ALU_OP_W-1:0] OP_ALL_ZEROS = 6'b010000;
    localparam logic [ALU_OP_W-1:0] OP_A_AND_B   = 6'b010001;
    localparam logic [ALU_OP_W-1:0] OP_A_OR_B    = 6'b010010;
    localparam logic [ALU_OP_W-1:0] OP_A_XOR_B   = 6'b010011;
    localparam logic [ALU_OP_W-1:0] OP_ALL_ONES  = 6'b011111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above
// ptr, wrapping around. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;
    int   cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept, one cycle
// of latch strobes, then a held valid/ready response to the granted requester.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | arbitrating; req_ready follows the winner combinationally
//   ST_EXEC | operands stable, latch strobes high for exactly one cycle
//   ST_RESP | rsp_valid to the owner, held until its rsp_ready
module alu_rr_sequencer
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [ALU_OP_W*NUM_REQ-1:0]  req_op,
    input  logic [ALU_W*NUM_REQ-1:0]     req_a,
    input  logic [ALU_W*NUM_REQ-1:0]     req_b,
    input  logic [NUM_REQ-1:0]           req_flags,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [ALU_W-1:0]             rsp_result,
    output logic                         rsp_zro,
    output logic                         rsp_neg,
    output logic                         rsp_carry,
    output logic [ALU_OP_W-1:0]          alu_op,
    output logic [ALU_W-1:0]             alu_a,
    output logic [ALU_W-1:0]             alu_b,
    output logic                         alu_latch_result,
    output logic                         alu_latch_flags,
    input  logic [ALU_W-1:0]             alu_result,
    input  logic                         alu_zro,
    input  logic                         alu_neg,
    input  logic                         alu_carry,
    output logic                         busy,
    output logic [CNT_W-1:0]             op_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    seq_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (win_oh),
        .grant_idx (win_idx)
    );

    assign req_ready  = (state == ST_IDLE) ? win_oh : '0;
    assign busy       = (state != ST_IDLE);
    assign rsp_result = alu_result;
    assign rsp_zro    = alu_zro;
    assign rsp_neg    = alu_neg;
    assign rsp_carry  = alu_carry;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            rr_ptr           <= '0;
            grant_idx        <= '0;
            grant_oh         <= '0;
            alu_op           <= '0;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_latch_result <= 1'b0;
            alu_latch_flags  <= 1'b0;
            rsp_valid        <= '0;
            op_count         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        alu_op           <= req_op[int'(win_idx)*ALU_OP_W +: ALU_OP_W];
                        alu_a            <= req_a[int'(win_idx)*ALU_W +: ALU_W];
                        alu_b            <= req_b[int'(win_idx)*ALU_W +: ALU_W];
                        alu_latch_result <= 1'b1;
                        alu_latch_flags  <= req_flags[win_idx];
                        grant_idx        <= win_idx;
                        grant_oh         <= win_oh;
                        rr_ptr           <= (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + 1'b1;
                        state            <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_latch_result <= 1'b0;
                    alu_latch_flags  <= 1'b0;
                    rsp_valid        <= grant_oh;
                    state            <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's rsp_ready can close the response.
                    if (rsp_ready[grant_idx]) begin
                        rsp_valid <= '0;
                        op_count  <= op_count + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
module tb_alu_rr_sequencer;
   import alu_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int CNT_W   = 4;

   logic                        clk = 1'b0;
   logic                        reset_n = 1'b0;
   logic [NUM_REQ-1:0]          req_valid = '0;
   logic [NUM_REQ-1:0]          req_ready;
   logic [ALU_OP_W*NUM_REQ-1:0] req_op = '0;
   logic [ALU_W*NUM_REQ-1:0]    req_a = '0;
   logic [ALU_W*NUM_REQ-1:0]    req_b = '0;
   logic [NUM_REQ-1:0]          req_flags = '0;
   logic [NUM_REQ-1:0]          rsp_valid;
   logic [NUM_REQ-1:0]          rsp_ready = '0;
   logic [ALU_W-1:0]            rsp_result;
   logic                        rsp_zro, rsp_neg, rsp_carry;
   logic [ALU_OP_W-1:0]         alu_op;
   logic [ALU_W-1:0]            alu_a, alu_b;
   logic                        alu_latch_result, alu_latch_flags;
   logic [ALU_W-1:0]            alu_result = '0;
   logic                        alu_zro = 1'b0, alu_neg = 1'b0, alu_carry = 1'b0;
   logic                        busy;
   logic [CNT_W-1:0]            op_count;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_rr_sequencer #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_flags(req_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zro(rsp_zro), .rsp_neg(rsp_neg), .rsp_carry(rsp_carry),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_latch_result(alu_latch_result), .alu_latch_flags(alu_latch_flags),
      .alu_result(alu_result), .alu_zro(alu_zro), .alu_neg(alu_neg), .alu_carry(alu_carry),
      .busy(busy), .op_count(op_count)
   );

   logic [ALU_W:0] alu_calc;
   always_comb begin
      alu_calc = '0;
      case (alu_op)
         OP_ADD:       alu_calc = {1'b0, alu_a} + {1'b0, alu_b};
         OP_SUB:       alu_calc = {1'b0, alu_a} - {1'b0, alu_b};
         OP_A_AND_B:   alu_calc = {1'b0, alu_a & alu_b};
         OP_ALL_ONES:  alu_calc = {1'b0, 16'hFFFF};
         OP_ALL_ZEROS: alu_calc = '0;
         default:      alu_calc = '0;
      endcase
   end
   always @(posedge clk) begin
      if (alu_latch_result) alu_result <= alu_calc[ALU_W-1:0];
      if (alu_latch_flags) begin
         alu_zro   <= (alu_calc[ALU_W-1:0] == '0);
         alu_neg   <= alu_calc[ALU_W-1];
         alu_carry <= alu_calc[ALU_W];
      end
   end

   task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic issue(input int r, input logic [5:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic f,
                        input logic [15:0] exp_res, input logic exp_zro);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      oh[r] = 1'b1;
      req_op[r*6 +: 6]   = op;
      req_a[r*16 +: 16]  = a;
      req_b[r*16 +: 16]  = b;
      req_flags[r]       = f;
      req_valid          = oh;
      #1;
      n_assert++; if (req_ready !== oh) fail("issue_req_ready", req_ready, oh);
      @(negedge clk);
      req_valid = '0;
      n_assert++; if (busy !== 1'b1) fail("exec_busy", busy, 1'b1);
      n_assert++; if (alu_latch_result !== 1'b1) fail("exec_latch_result", alu_latch_result, 1'b1);
      n_assert++; if (alu_latch_flags !== f) fail("exec_latch_flags", alu_latch_flags, f);
      n_assert++; if (alu_a !== a) fail("exec_alu_a", alu_a, a);
      n_assert++; if (rsp_valid !== 2'b00) fail("exec_rsp_valid", rsp_valid, 2'b00);
      @(negedge clk);
      n_assert++; if (rsp_valid !== oh) fail("resp_rsp_valid", rsp_valid, oh);
      n_assert++; if (rsp_result !== exp_res) fail("resp_result", rsp_result, exp_res);
      n_assert++; if (rsp_zro !== exp_zro) fail("resp_zro", rsp_zro, exp_zro);
      @(negedge clk);
      n_assert++; if (rsp_valid !== 2'b00) fail("post_rsp_valid", rsp_valid, 2'b00);
      n_assert++; if (busy !== 1'b0) fail("post_busy", busy, 1'b0);
   endtask

   logic [NUM_REQ-1:0] exp_oh;
   logic [15:0]        exp_res;
   logic [5:0]         hold_op;
   logic [15:0]        hold_a, hold_b, hold_res;

   initial begin
      repeat (2) @(negedge clk);
      n_assert++; if (busy !== 1'b0) fail("rst_busy", busy, 1'b0);
      n_assert++; if (req_ready !== 2'b00) fail("rst_req_ready", req_ready, 2'b00);
      n_assert++; if (rsp_valid !== 2'b00) fail("rst_rsp_valid", rsp_valid, 2'b00);
      n_assert++; if (op_count !== 4'd0) fail("rst_op_count", op_count, 4'd0);
      n_assert++; if (alu_op !== 6'd0) fail("rst_alu_op", alu_op, 6'd0);
      n_assert++; if (alu_a !== 16'd0) fail("rst_alu_a", alu_a, 16'd0);
      n_assert++; if ({alu_latch_result, alu_latch_flags} !== 2'b00)
         fail("rst_latch", {alu_latch_result, alu_latch_flags}, 2'b00);
      reset_n = 1'b1;
      rsp_ready = 2'b11;
      @(negedge clk);

      issue(0, OP_ADD, 16'h0003, 16'h0004, 1'b1, 16'h0007, 1'b0);
      n_assert++; if (op_count !== 4'd1) fail("single_op_count", op_count, 4'd1);

      issue(1, OP_ALL_ZEROS, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b1);
      issue(1, OP_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b1);
      n_assert++; if (op_count !== 4'd3) fail("retain_op_count", op_count, 4'd3);

      issue(1, OP_SUB, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0);
      n_assert++; if (rsp_neg !== 1'b1) fail("sub_neg", rsp_neg, 1'b1);
      n_assert++; if (rsp_carry !== 1'b1) fail("sub_carry", rsp_carry, 1'b1);
      n_assert++; if (op_count !== 4'd4) fail("sub_op_count", op_count, 4'd4);

      req_op = {OP_A_AND_B, OP_ADD};
      req_a = {16'h00FF, 16'h0010};
      req_b = {16'h0F0F, 16'h0001};
      req_flags = 2'b11;
      req_valid = 2'b11;
      for (int i = 0; i < 6; i++) begin
         exp_oh  = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_res = (i % 2 == 0) ? 16'h0011 : 16'h000F;
         #1;
         n_assert++; if (req_ready !== exp_oh) fail("fair_grant", req_ready, exp_oh);
         @(negedge clk);
         @(negedge clk);
         n_assert++; if (rsp_valid !== exp_oh) fail("fair_rsp_valid", rsp_valid, exp_oh);
         n_assert++; if (rsp_result !== exp_res) fail("fair_result", rsp_result, exp_res);
         @(negedge clk);
      end
      n_assert++; if (op_count !== 4'd10) fail("fair_op_count", op_count, 4'd10);

      req_op = {OP_A_AND_B, OP_SUB};
      req_a = {16'h00F0, 16'h0009};
      req_b = {16'h0FF0, 16'h0002};
      rsp_ready = 2'b00;
      #1;
      n_assert++; if (req_ready !== 2'b01) fail("bp_grant0", req_ready, 2'b01);
      @(negedge clk);
      req_valid = 2'b10;
      @(negedge clk);
      n_assert++; if (rsp_valid !== 2'b01) fail("bp_rsp_valid0", rsp_valid, 2'b01);
      n_assert++; if (rsp_result !== 16'h0007) fail("bp_result0", rsp_result, 16'h0007);
      hold_op = alu_op; hold_a = alu_a; hold_b = alu_b; hold_res = rsp_result;
      rsp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_assert++; if (rsp_valid !== 2'b01) fail("bp_hold_valid", rsp_valid, 2'b01);
         n_assert++; if (req_ready !== 2'b00) fail("bp_hold_req_ready", req_ready, 2'b00);
         n_assert++;
         if ({alu_op, alu_a, alu_b, rsp_result} !== {hold_op, hold_a, hold_b, hold_res})
            fail("bp_hold_ops", {alu_op, alu_a, alu_b, rsp_result}, {hold_op, hold_a, hold_b, hold_res});
      end
      n_assert++; if (op_count !== 4'd10) fail("bp_op_count_held", op_count, 4'd10);
      rsp_ready = 2'b01;
      @(negedge clk);
      n_assert++; if (rsp_valid !== 2'b00) fail("bp_after_valid", rsp_valid, 2'b00);
      n_assert++; if (req_ready !== 2'b10) fail("bp_after_grant1", req_ready, 2'b10);
      n_assert++; if (op_count !== 4'd11) fail("bp_after_count", op_count, 4'd11);
      rsp_ready = 2'b11;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      n_assert++; if (rsp_valid !== 2'b10) fail("bp_rsp_valid1", rsp_valid, 2'b10);
      n_assert++; if (rsp_result !== 16'h00F0) fail("bp_result1", rsp_result, 16'h00F0);
      @(negedge clk);
      n_assert++; if (op_count !== 4'd12) fail("bp_count2", op_count, 4'd12);

      issue(0, OP_ALL_ONES, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0);
      issue(1, OP_ADD, 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0);
      issue(0, OP_ADD, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1);
      n_assert++; if (op_count !== 4'd15) fail("wrap_pre", op_count, 4'd15);
      issue(1, OP_ADD, 16'h0010, 16'h0020, 1'b1, 16'h0030, 1'b0);
      n_assert++; if (op_count !== 4'd0) fail("wrap_zero", op_count, 4'd0);

      req_op[5:0] = OP_ADD; req_a[15:0] = 16'h0100; req_b[15:0] = 16'h0001;
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      n_assert++; if (busy !== 1'b1) fail("rstx_in_exec", busy, 1'b1);
      reset_n = 1'b0;
      #2;
      n_assert++; if (busy !== 1'b0) fail("rstx_busy", busy, 1'b0);
      n_assert++; if (rsp_valid !== 2'b00) fail("rstx_rsp_valid", rsp_valid, 2'b00);
      n_assert++; if (op_count !== 4'd0) fail("rstx_op_count", op_count, 4'd0);
      n_assert++; if ({alu_op, alu_a} !== 22'd0) fail("rstx_alu_op", {alu_op, alu_a}, 22'd0);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_assert++; if (rsp_valid !== 2'b00) fail("rstx_no_rsp", rsp_valid, 2'b00);
      end
      req_valid = 2'b11;
      #1;
      n_assert++; if (req_ready !== 2'b01) fail("rstx_ptr_zero", req_ready, 2'b01);
      req_valid = 2'b00;
      issue(0, OP_ADD, 16'h0005, 16'h0006, 1'b1, 16'h000B, 1'b0);
      n_assert++; if (op_count !== 4'd1) fail("rstx_served_count", op_count, 4'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
